// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment display driver.
// Patterns are active-high "segment on", bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    localparam logic [6:0] SEG_OFF = '0;
    localparam logic [6:0] SEG_ALL = '1;

    // Converts an active-high pattern to the board's drive polarity.
    function automatic logic [6:0] seg7_polarity(input logic [6:0] pattern,
                                                  input logic        active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational hex-digit decoder: 4-bit code in, active-high segments out.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Full 16-entry hex decode
    always_comb begin
        segments = SEG_OFF;
        case (digit)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_display.sv
// Registered seven-segment driver for the score/winner readout.
// Lamp test beats blank, blank beats load; the output register is the only state.
module seg7_display
    import seg7_pkg::*;
#(
    parameter int IN_WIDTH   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                en,
    input  logic [IN_WIDTH-1:0] value,
    input  logic                blank,
    input  logic                lamp_test,
    output logic [6:0]          out
);

    localparam logic INVERT = (ACTIVE_LOW != 0);

    logic [3:0] digit;
    logic [6:0] decoded;
    logic [6:0] next_out;

    // Zero-extend the count to a full hex digit
    always_comb begin
        digit = '0;
        digit[IN_WIDTH-1:0] = value;
    end

    seg7_lut u_lut (
        .digit    (digit),
        .segments (decoded)
    );

    // Per-cycle priority select; holds when nothing is requested
    always_comb begin
        next_out = out;
        if (lamp_test)
            next_out = seg7_polarity(SEG_ALL, INVERT);
        else if (blank)
            next_out = seg7_polarity(SEG_OFF, INVERT);
        else if (en)
            next_out = seg7_polarity(decoded, INVERT);
    end

    // Output register with synchronous reset to all segments off
    always_ff @(posedge Clock) begin
        if (Reset)
            out <= seg7_polarity(SEG_OFF, INVERT);
        else
            out <= next_out;
    end

endmodule

// File: tb/tb_seg7_display.sv
// Bench for seg7_display: default build (3-bit, active-low) and a
// 4-bit active-high build, driven from vector tables with a scoreboard.
module tb_seg7_display;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Default-parameter instance
    logic       r1, en1, bl1, lt1;
    logic [2:0] v1;
    logic [6:0] out1;

    // IN_WIDTH=4, ACTIVE_LOW=0 instance
    logic       r2, en2, bl2, lt2;
    logic [3:0] v2;
    logic [6:0] out2;

    seg7_display dut_def (
        .Clock     (Clock),
        .Reset     (r1),
        .en        (en1),
        .value     (v1),
        .blank     (bl1),
        .lamp_test (lt1),
        .out       (out1)
    );

    seg7_display #(.IN_WIDTH(4), .ACTIVE_LOW(0)) dut_hex (
        .Clock     (Clock),
        .Reset     (r2),
        .en        (en2),
        .value     (v2),
        .blank     (bl2),
        .lamp_test (lt2),
        .out       (out2)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] value;
        logic       blank;
        logic       lamp;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        int         dut;
        int         step;
        logic [6:0] exp;
    } sb_t;

    vec_t tbl1[$];
    vec_t tbl2[$];
    sb_t  sbq[$];
    int   errors = 0;
    int   checks = 0;
    logic [6:0] hex_ah [16];

    function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] value,
                                input logic blank, input logic lamp, input logic [6:0] exp);
        vec_t v;
        v.rst = rst; v.en = en; v.value = value; v.blank = blank; v.lamp = lamp; v.exp = exp;
        return v;
    endfunction

    task automatic compare(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: out=%b expected=%b", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, queue its expectation, check after the rising edge
    task automatic apply(input int dut, input int step, input vec_t v);
        sb_t e;
        @(negedge Clock);
        if (dut == 0) begin
            r1 = v.rst; en1 = v.en; v1 = v.value[2:0]; bl1 = v.blank; lt1 = v.lamp;
        end else begin
            r2 = v.rst; en2 = v.en; v2 = v.value; bl2 = v.blank; lt2 = v.lamp;
        end
        sbq.push_back('{dut: dut, step: step, exp: v.exp});
        @(posedge Clock);
        #1;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at step %0d", step);
        end else begin
            e = sbq.pop_front();
            if (((e.dut == 0) ? out1 : out2) !== e.exp) begin
                errors++;
                $display("FAIL dut%0d step %0d: out=%b expected=%b",
                         e.dut, e.step, (e.dut == 0) ? out1 : out2, e.exp);
            end
        end
    endtask

    initial begin
        r1 = 1'b0; en1 = 1'b0; v1 = '0; bl1 = 1'b0; lt1 = 1'b0;
        r2 = 1'b0; en2 = 1'b0; v2 = '0; bl2 = 1'b0; lt2 = 1'b0;

        hex_ah = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                   7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                   7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

        // Default build, active-low expectations: {rst, en, value, blank, lamp, exp}
        tbl1.push_back(mk(1, 0, 0, 0, 0, 7'h7F));        // reset
        tbl1.push_back(mk(0, 1, 0, 0, 0, 7'b1000000));   // first load after release
        tbl1.push_back(mk(0, 1, 1, 0, 0, 7'b1111001));
        tbl1.push_back(mk(0, 1, 2, 0, 0, 7'b0100100));
        tbl1.push_back(mk(0, 1, 3, 0, 0, 7'b0110000));
        tbl1.push_back(mk(0, 1, 4, 0, 0, 7'b0011001));
        tbl1.push_back(mk(0, 1, 5, 0, 0, 7'b0010010));
        tbl1.push_back(mk(0, 1, 6, 0, 0, 7'b0000010));
        tbl1.push_back(mk(0, 1, 7, 0, 0, 7'b1111000));
        tbl1.push_back(mk(0, 1, 2, 0, 0, 7'b0100100));   // hold sequence
        tbl1.push_back(mk(0, 0, 5, 0, 0, 7'b0100100));
        tbl1.push_back(mk(0, 0, 7, 0, 0, 7'b0100100));
        tbl1.push_back(mk(0, 1, 5, 0, 0, 7'b0010010));
        tbl1.push_back(mk(0, 1, 5, 1, 0, 7'h7F));        // blank over load
        tbl1.push_back(mk(0, 1, 5, 1, 1, 7'h00));        // lamp over blank
        tbl1.push_back(mk(0, 0, 5, 0, 1, 7'h00));        // lamp without en
        tbl1.push_back(mk(0, 1, 3, 0, 0, 7'b0110000));
        tbl1.push_back(mk(0, 0, 3, 1, 0, 7'h7F));        // blank without en
        tbl1.push_back(mk(0, 0, 4, 0, 0, 7'h7F));        // hold blanked
        tbl1.push_back(mk(0, 1, 6, 0, 0, 7'b0000010));   // reset mid-stream
        tbl1.push_back(mk(1, 1, 6, 0, 0, 7'h7F));
        tbl1.push_back(mk(0, 1, 6, 0, 0, 7'b0000010));
        tbl1.push_back(mk(1, 1, 6, 0, 1, 7'h7F));        // reset beats lamp test
        tbl1.push_back(mk(0, 0, 1, 0, 0, 7'h7F));        // hold after reset

        foreach (tbl1[i]) apply(0, i, tbl1[i]);

        // Hex build, active-high: reset, full 0..F sweep, overrides
        tbl2.push_back(mk(1, 1, 4'hA, 0, 0, 7'h00));
        for (int unsigned d = 0; d < 16; d++)
            tbl2.push_back(mk(0, 1, 4'(d), 0, 0, hex_ah[d]));
        tbl2.push_back(mk(0, 0, 4'h3, 0, 1, 7'h7F));
        tbl2.push_back(mk(0, 0, 4'h3, 1, 0, 7'h00));
        tbl2.push_back(mk(0, 1, 4'hA, 0, 0, 7'b1110111));
        tbl2.push_back(mk(1, 0, 4'hA, 0, 0, 7'h00));

        foreach (tbl2[i]) apply(1, i, tbl2[i]);

        // Hand sequence: a new input must not reach out before the clock edge
        @(negedge Clock);
        r1 = 1'b0; en1 = 1'b1; v1 = 3'd1; bl1 = 1'b0; lt1 = 1'b0;
        @(posedge Clock); #1;
        compare("load_one", out1, 7'b1111001);
        @(negedge Clock);
        v1 = 3'd7;
        #1;
        compare("no_comb_value", out1, 7'b1111001);
        lt1 = 1'b1;
        #1;
        compare("no_comb_lamp", out1, 7'b1111001);
        @(posedge Clock); #1;
        compare("lamp_lands", out1, 7'h00);
        @(negedge Clock);
        lt1 = 1'b0; en1 = 1'b0;
        @(posedge Clock); #1;
        compare("lamp_held", out1, 7'h00);
        @(negedge Clock);
        en1 = 1'b1;
        @(posedge Clock); #1;
        compare("reload_seven", out1, 7'b1111000);

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
